// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and status flags.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b100,
    SUB = 3'b010,
    AND = 3'b001,
    OR  = 3'b110,
    XOR = 3'b011,
    SHL = 3'b101,
    SHR = 3'b111
  } aluFun_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } aluFlags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between producer, ALU pipe and consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  aluFun_t          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  aluFlags_t        flags;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, op_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, op_count
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, op -> result and status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluFun_t          op,
  output logic [WIDTH-1:0] result,
  output aluFlags_t        flags
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] res;
  aluFlags_t        fl;

  always_comb begin
    shamt   = b[SH_W-1:0];
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    // One guard bit on the far side of each shift catches the last bit shifted out.
    shl_ext = {1'b0, a} << shamt;
    shr_ext = {a, 1'b0} >> shamt;
    res     = '0;
    fl      = '0;
    case (op)
      ADD: begin
        res      = sum[WIDTH-1:0];
        fl.carry = sum[WIDTH];
        fl.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        res      = diff[WIDTH-1:0];
        fl.carry = diff[WIDTH];
        fl.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      AND: res = a & b;
      OR:  res = a | b;
      XOR: res = a ^ b;
      SHL: begin
        res      = shl_ext[WIDTH-1:0];
        fl.carry = shl_ext[WIDTH];
      end
      SHR: begin
        res      = shr_ext[WIDTH:1];
        fl.carry = shr_ext[0];
      end
      default: fl.illegal = 1'b1;
    endcase
    // Illegal ops report only the illegal flag, not zero for their forced-0 result.
    if (!fl.illegal) begin
      fl.zero = (res == '0);
      fl.neg  = res[WIDTH-1];
    end
    result = res;
    flags  = fl;
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipe: S1 holds operands, S2 holds result/flags; valid/ready on both ends.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic       clock,
  input logic       reset,
  alu_pipe_if.slave bus
);
  logic [2:1]       vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b;
  aluFun_t          s1_op;
  logic [WIDTH-1:0] s2_result, core_result;
  aluFlags_t        s2_flags, core_flags;
  logic [CNT_W-1:0] cnt;
  logic             s2_load, in_ready, accept, fire;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  // S1 may refill in the same cycle it hands off to S2, so no bubble while flowing.
  assign s2_load  = vld_pipe[1] && (!vld_pipe[2] || bus.out_ready);
  assign in_ready = !vld_pipe[1] || s2_load;
  assign accept   = bus.in_valid && in_ready;
  assign fire     = vld_pipe[2] && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= ADD;
      s2_result <= '0;
      s2_flags  <= '0;
      cnt       <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= bus.in_valid;
      if (accept) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= bus.op;
      end
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        s2_result   <= core_result;
        s2_flags    <= core_flags;
      end else if (bus.out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
      if (fire && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_pipe[2];
  assign bus.result    = s2_result;
  assign bus.flags     = s2_flags;
  assign bus.op_count  = cnt;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: arithmetic, flags, backpressure, async reset, counter saturation.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  alu_pipe_if #(.WIDTH(8), .CNT_W(2))  sbus ();

  alu_pipe #(.WIDTH(8), .CNT_W(16)) dut   (.clock(clock), .reset(reset), .bus(bus.slave));
  alu_pipe #(.WIDTH(8), .CNT_W(2))  u_sat (.clock(clock), .reset(reset), .bus(sbus.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input aluFun_t o, input logic [7:0] x, input logic [7:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  // Issue one op into an empty pipe and check the emerging result (bounded wait).
  task automatic one(input string tag, input aluFun_t o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] er, input logic [4:0] ef);
    int n;
    @(negedge clock);
    drive(1'b1, o, x, y);
    @(negedge clock);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".res"},   bus.result, er);
    chk({tag, ".flags"}, bus.flags, ef);
  endtask

  aluFun_t    ops [5] = '{ADD, SUB, AND, OR, XOR};
  logic [7:0] b2b [5] = '{8'h4a, 8'h20, 8'h15, 8'h35, 8'h20};
  logic [1:0] cexp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    int n;
    drive(1'b0, ADD, 8'h00, 8'h00);
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.op        = ADD;
    sbus.a         = '0;
    sbus.b         = '0;
    sbus.out_ready = 1'b1;

    repeat (2) @(negedge clock);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.result",    bus.result, 0);
    chk("rst.flags",     bus.flags, 0);
    chk("rst.op_count",  bus.op_count, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.in_ready",  bus.in_ready, 1);

    // Back-to-back stream, one op per cycle, results two cycles after presentation.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 1) chk("b2b.latency", bus.out_valid, 0);
      if (i >= 2 && i < 7) begin
        chk("b2b.valid", bus.out_valid, 1);
        chk("b2b.res",   bus.result, b2b[i-2]);
        chk("b2b.flags", bus.flags, 0);
      end
      if (i < 5) drive(1'b1, ops[i], 8'h35, 8'h15);
      else bus.in_valid = 1'b0;
    end
    chk("b2b.drained", bus.out_valid, 0);
    chk("b2b.count",   bus.op_count, 5);

    //                                       flags = {zero,neg,carry,ovf,illegal}
    one("add_ff_01", ADD, 8'hFF, 8'h01, 8'h00, 5'b10100);
    one("add_7f_01", ADD, 8'h7F, 8'h01, 8'h80, 5'b01010);
    one("sub_00_01", SUB, 8'h00, 8'h01, 8'hFF, 5'b01100);
    one("sub_80_01", SUB, 8'h80, 8'h01, 8'h7F, 5'b00010);
    one("shl_81_1",  SHL, 8'h81, 8'h01, 8'h02, 5'b00100);
    one("shr_81_0",  SHR, 8'h81, 8'h00, 8'h81, 5'b01000);
    one("shr_81_1",  SHR, 8'h81, 8'h01, 8'h40, 5'b00100);
    one("illegal",   aluFun_t'(3'b000), 8'h12, 8'h34, 8'h00, 5'b00001);

    // Backpressure: two accepts fill the pipe, third op waits.
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive(1'b1, ADD, 8'h01, 8'h02);
    #1 chk("bp.ready0", bus.in_ready, 1);
    @(negedge clock);
    drive(1'b1, XOR, 8'h0F, 8'hF0);
    #1 chk("bp.ready1", bus.in_ready, 1);
    @(negedge clock);
    drive(1'b1, OR, 8'h10, 8'h01);
    #1 chk("bp.ready_low", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp.hold_valid", bus.out_valid, 1);
      chk("bp.hold_res",   bus.result, 8'h03);
      chk("bp.hold_flags", bus.flags, 0);
      chk("bp.hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp.release_ready", bus.in_ready, 1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("bp.r1_valid", bus.out_valid, 1);
    chk("bp.r1_res",   bus.result, 8'hFF);
    chk("bp.r1_flags", bus.flags, 5'b01000);
    @(negedge clock);
    chk("bp.r2_valid", bus.out_valid, 1);
    chk("bp.r2_res",   bus.result, 8'h11);
    @(negedge clock);
    chk("bp.no_dup",   bus.out_valid, 0);
    chk("bp.count",    bus.op_count, 16);

    // Async reset with both stages full.
    bus.out_ready = 1'b0;
    drive(1'b1, ADD, 8'h01, 8'h01);
    @(negedge clock);
    drive(1'b1, ADD, 8'h02, 8'h02);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("mid.full_valid", bus.out_valid, 1);
    chk("mid.full_res",   bus.result, 8'h02);
    #2 reset = 1'b1;
    #1;
    chk("mid.async_valid", bus.out_valid, 0);
    chk("mid.async_count", bus.op_count, 0);
    chk("mid.async_res",   bus.result, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("mid.in_ready", bus.in_ready, 1);
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.out_valid) stale++;
    end
    chk("mid.no_stale", stale, 0);
    one("mid.fresh", ADD, 8'h03, 8'h04, 8'h07, 5'b00000);
    @(negedge clock);
    chk("mid.count1", bus.op_count, 1);

    // Narrow counter saturates at all-ones.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      sbus.in_valid = 1'b1;
      sbus.op       = ADD;
      sbus.a        = 8'(i);
      sbus.b        = 8'h01;
      @(negedge clock);
      sbus.in_valid = 1'b0;
      n = 0;
      while (!sbus.out_valid && n < 8) begin
        @(negedge clock);
        n++;
      end
      chk("sat.valid", sbus.out_valid, 1);
      chk("sat.res",   sbus.result, 8'(i + 1));
      @(negedge clock);
      chk("sat.count", sbus.op_count, cexp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
